kbd_ctrl: RTL

Front-end controller for the keyboard path. It receives raw PS/2 device-to-host frames and sequences the scan-code translator. It maintains the 3-byte scan history that the translator consumes, and decodes E0/F0/E1 prefix sequences into discrete make/break events. It tracks shift state, recovers from framing errors and timeouts, and counts errors.

---
 rtl/kbd_pkg.sv | 41 ++++
 rtl/kbd_ctrl_ps2_rx.sv | 153 +++++++++++++++
 rtl/kbd_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared constants, state encodings and code classifiers for the keyboard front end.
package kbd_pkg;

   localparam logic [7:0] PFX_EXT    = 8'hE0;
   localparam logic [7:0] PFX_BRK    = 8'hF0;
   localparam logic [7:0] PFX_PAUSE  = 8'hE1;

   localparam logic [7:0] IGN_BAT    = 8'hAA;
   localparam logic [7:0] IGN_ACK    = 8'hFA;
   localparam logic [7:0] IGN_RESEND = 8'hFE;
   localparam logic [7:0] IGN_ECHO   = 8'hEE;

   localparam logic [7:0] KEY_LSHIFT = 8'h12;
   localparam logic [7:0] KEY_RSHIFT = 8'h59;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PAR,
      RX_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      S_BASE,
      S_EXT,
      S_BRK,
      S_EXT_BRK,
      S_PAUSE
   } dec_state_t;

   // Device housekeeping replies that never produce a key event.
   function automatic logic is_ignore(input logic [7:0] code);
      return (code == IGN_BAT) || (code == IGN_ACK) ||
             (code == IGN_RESEND) || (code == IGN_ECHO);
   endfunction

   function automatic logic is_shift(input logic [7:0] code);
      return (code == KEY_LSHIFT) || (code == KEY_RSHIFT);
   endfunction

endpackage

// File: rtl/kbd_ctrl_ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronisers, clock glitch filter,
// 11-bit frame FSM with odd-parity/stop checking and inter-edge timeout.
module ps2_rx
   import kbd_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 5000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic       byte_vld,
   output logic [7:0] rx_byte,
   output logic       err
);

   localparam int FILT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

   logic [1:0]        clk_sync_reg;
   logic [1:0]        dat_sync_reg;
   logic              filt_lvl_reg;
   logic [FILT_W-1:0] filt_cnt_reg;
   logic              filt_differ;
   logic              filt_flip;
   logic              fall;
   logic              dat;

   rx_state_t   state_reg, state_next;
   logic [7:0]  shift_reg, shift_next;
   logic [2:0]  bit_cnt_reg, bit_cnt_next;
   logic        par_reg, par_next;
   logic [15:0] tmo_reg, tmo_next;
   logic        vld_reg, vld_next;
   logic        err_reg, err_next;

   // Lines idle high, so the synchronisers and filter start high to avoid a
   // phantom falling edge right after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_reg <= 2'b11;
         dat_sync_reg <= 2'b11;
      end else begin
         clk_sync_reg <= {clk_sync_reg[0], ps2_clk};
         dat_sync_reg <= {dat_sync_reg[0], ps2_dat};
      end
   end

   always_comb begin
      filt_differ = (clk_sync_reg[1] != filt_lvl_reg);
      filt_flip   = filt_differ && (filt_cnt_reg == FILT_W'(FILTER_LEN - 1));
      fall        = filt_flip && filt_lvl_reg;
      dat         = dat_sync_reg[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_lvl_reg <= 1'b1;
         filt_cnt_reg <= '0;
      end else if (filt_flip) begin
         filt_lvl_reg <= ~filt_lvl_reg;
         filt_cnt_reg <= '0;
      end else if (filt_differ) begin
         filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end else begin
         filt_cnt_reg <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= RX_IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         par_reg     <= 1'b0;
         tmo_reg     <= '0;
         vld_reg     <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         bit_cnt_reg <= bit_cnt_next;
         par_reg     <= par_next;
         tmo_reg     <= tmo_next;
         vld_reg     <= vld_next;
         err_reg     <= err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt_reg;
      par_next     = par_reg;
      tmo_next     = tmo_reg;
      vld_next     = 1'b0;
      err_next     = 1'b0;

      case (state_reg)
         RX_IDLE: begin
            tmo_next = '0;
            if (fall && !dat) begin
               state_next   = RX_DATA;
               bit_cnt_next = '0;
            end
         end
         RX_DATA: begin
            if (fall) begin
               shift_next   = {dat, shift_reg[7:1]};
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
                  state_next = RX_PAR;
               end
            end
         end
         RX_PAR: begin
            if (fall) begin
               par_next   = dat;
               state_next = RX_STOP;
            end
         end
         RX_STOP: begin
            if (fall) begin
               if (dat && (^{par_reg, shift_reg})) begin
                  vld_next = 1'b1;
               end else begin
                  err_next = 1'b1;
               end
               state_next = RX_IDLE;
            end
         end
         default: state_next = RX_IDLE;
      endcase

      // Inter-edge watchdog; a stalled device abandons the partial frame.
      if (state_reg != RX_IDLE) begin
         if (fall) begin
            tmo_next = '0;
         end else if (tmo_reg == 16'(TIMEOUT_CYC - 1)) begin
            err_next   = 1'b1;
            state_next = RX_IDLE;
            tmo_next   = '0;
         end else begin
            tmo_next = tmo_reg + 16'd1;
         end
      end
   end

   assign byte_vld = vld_reg;
   assign rx_byte  = shift_reg;
   assign err      = err_reg;

endmodule

// File: rtl/kbd_ctrl.sv
// Keyboard front end: scan history for the translator, prefix decoding into
// make/break events, shift tracking and a saturating error counter.
module kbd_ctrl
   import kbd_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 5000,
   parameter int PAUSE_SKIP  = 7
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iPS2_CLK,
   input  logic        iPS2_DAT,
   output logic [23:0] oHIST,
   output logic        oHIST_STB,
   output logic        oEVT_VALID,
   output logic [7:0]  oEVT_CODE,
   output logic        oEVT_EXT,
   output logic        oEVT_BRK,
   output logic        oSHIFT,
   output logic [7:0]  oERR_CNT
);

   logic       byte_vld;
   logic [7:0] rx_byte;
   logic       rx_err;

   ps2_rx #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk      (iCLK),
      .rst_n    (iRST_N),
      .ps2_clk  (iPS2_CLK),
      .ps2_dat  (iPS2_DAT),
      .byte_vld (byte_vld),
      .rx_byte  (rx_byte),
      .err      (rx_err)
   );

   dec_state_t  dec_reg, dec_next;
   logic [23:0] hist_reg, hist_next;
   logic        hist_stb_reg, hist_stb_next;
   logic [7:0]  skip_reg, skip_next;
   logic        evt_valid_reg, evt_valid_next;
   logic [7:0]  evt_code_reg, evt_code_next;
   logic        evt_ext_reg, evt_ext_next;
   logic        evt_brk_reg, evt_brk_next;
   logic        shift_reg, shift_next;
   logic [7:0]  err_cnt_reg, err_cnt_next;
   logic        emit;
   logic        emit_ext;
   logic        emit_brk;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         dec_reg       <= S_BASE;
         hist_reg      <= '0;
         hist_stb_reg  <= 1'b0;
         skip_reg      <= '0;
         evt_valid_reg <= 1'b0;
         evt_code_reg  <= '0;
         evt_ext_reg   <= 1'b0;
         evt_brk_reg   <= 1'b0;
         shift_reg     <= 1'b0;
         err_cnt_reg   <= '0;
      end else begin
         dec_reg       <= dec_next;
         hist_reg      <= hist_next;
         hist_stb_reg  <= hist_stb_next;
         skip_reg      <= skip_next;
         evt_valid_reg <= evt_valid_next;
         evt_code_reg  <= evt_code_next;
         evt_ext_reg   <= evt_ext_next;
         evt_brk_reg   <= evt_brk_next;
         shift_reg     <= shift_next;
         err_cnt_reg   <= err_cnt_next;
      end
   end

   always_comb begin
      dec_next       = dec_reg;
      hist_next      = hist_reg;
      hist_stb_next  = 1'b0;
      skip_next      = skip_reg;
      evt_valid_next = 1'b0;
      evt_code_next  = evt_code_reg;
      evt_ext_next   = evt_ext_reg;
      evt_brk_next   = evt_brk_reg;
      shift_next     = shift_reg;
      err_cnt_next   = err_cnt_reg;
      emit           = 1'b0;
      emit_ext       = 1'b0;
      emit_brk       = 1'b0;

      if (rx_err) begin
         // Zeroed history forces the translator output to 0 until fresh bytes arrive.
         hist_next  = '0;
         dec_next   = S_BASE;
         skip_next  = '0;
         shift_next = 1'b0;
         if (err_cnt_reg != 8'hFF) begin
            err_cnt_next = err_cnt_reg + 8'd1;
         end
      end else if (byte_vld) begin
         hist_next     = {hist_reg[15:0], rx_byte};
         hist_stb_next = 1'b1;

         case (dec_reg)
            S_BASE: begin
               if (rx_byte == PFX_EXT) begin
                  dec_next = S_EXT;
               end else if (rx_byte == PFX_BRK) begin
                  dec_next = S_BRK;
               end else if (rx_byte == PFX_PAUSE) begin
                  dec_next  = S_PAUSE;
                  skip_next = 8'(PAUSE_SKIP);
               end else if (!is_ignore(rx_byte)) begin
                  emit = 1'b1;
               end
            end
            S_EXT: begin
               if (rx_byte == PFX_BRK) begin
                  dec_next = S_EXT_BRK;
               end else begin
                  emit     = 1'b1;
                  emit_ext = 1'b1;
                  dec_next = S_BASE;
               end
            end
            S_BRK: begin
               emit     = 1'b1;
               emit_brk = 1'b1;
               dec_next = S_BASE;
            end
            S_EXT_BRK: begin
               emit     = 1'b1;
               emit_ext = 1'b1;
               emit_brk = 1'b1;
               dec_next = S_BASE;
            end
            S_PAUSE: begin
               if (skip_reg <= 8'd1) begin
                  skip_next = '0;
                  dec_next  = S_BASE;
               end else begin
                  skip_next = skip_reg - 8'd1;
               end
            end
            default: dec_next = S_BASE;
         endcase

         if (emit) begin
            evt_valid_next = 1'b1;
            evt_code_next  = rx_byte;
            evt_ext_next   = emit_ext;
            evt_brk_next   = emit_brk;
            // E0-prefixed events share codes with shift keys but are different keys.
            if (!emit_ext && is_shift(rx_byte)) begin
               shift_next = !emit_brk;
            end
         end
      end
   end

   assign oHIST      = hist_reg;
   assign oHIST_STB  = hist_stb_reg;
   assign oEVT_VALID = evt_valid_reg;
   assign oEVT_CODE  = evt_code_reg;
   assign oEVT_EXT   = evt_ext_reg;
   assign oEVT_BRK   = evt_brk_reg;
   assign oSHIFT     = shift_reg;
   assign oERR_CNT   = err_cnt_reg;

endmodule
